// File: rtl/acc_sequencer.sv
// Accumulator write sequencer for the BeeF core.
// Drives acc_write/acc_src for repeated ALU writes and timed memory loads.
module acc_sequencer #(
   parameter int COUNT_W     = 8,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [COUNT_W-1:0] cmd_count,
   output logic               mem_req,
   input  logic               mem_ack,
   output logic               acc_write,
   output logic               acc_src,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_ALU  = 2'b01;
   localparam logic [1:0] OP_LOAD = 2'b10;
   localparam logic [1:0] OP_RES  = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      ALU_RUN,
      MEM_REQ,
      FIN
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [COUNT_W-1:0] rem_q;
   logic [COUNT_W-1:0] rem_nxt;
   logic [WAIT_W-1:0]  wait_q;
   logic [WAIT_W-1:0]  wait_nxt;
   logic               err_q;
   logic               err_nxt;
   logic               accept;
   logic               write_c;
   logic               src_c;
   logic               req_c;
   logic               done_c;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state  <= IDLE;
         rem_q  <= '0;
         wait_q <= '0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         rem_q  <= rem_nxt;
         wait_q <= wait_nxt;
         err_q  <= err_nxt;
      end
   end

   assign accept = cmd_valid && cmd_ready;

   always_comb begin
      state_nxt = state;
      rem_nxt   = rem_q;
      wait_nxt  = wait_q;
      err_nxt   = err_q;
      write_c   = 1'b0;
      src_c     = 1'b0;
      req_c     = 1'b0;
      done_c    = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               err_nxt = 1'b0;
               unique case (cmd_op)
                  OP_ALU: begin
                     state_nxt = ALU_RUN;
                     // a zero count still performs one write
                     rem_nxt   = (cmd_count == '0) ? COUNT_W'(1)
                                                   : cmd_count;
                  end
                  OP_LOAD: begin
                     state_nxt = MEM_REQ;
                     wait_nxt  = '0;
                  end
                  OP_NOP: begin
                     state_nxt = FIN;
                  end
                  OP_RES: begin
                     state_nxt = FIN;
                     err_nxt   = 1'b1;
                  end
               endcase
            end
         end
         ALU_RUN: begin
            write_c = 1'b1;
            rem_nxt = rem_q - 1'b1;
            if (rem_q == COUNT_W'(1)) begin
               done_c    = 1'b1;
               state_nxt = IDLE;
            end
         end
         MEM_REQ: begin
            req_c = 1'b1;
            src_c = 1'b1;
            if (mem_ack) begin
               write_c   = 1'b1;
               done_c    = 1'b1;
               state_nxt = IDLE;
            end else if (wait_q == WAIT_LAST) begin
               err_nxt   = 1'b1;
               done_c    = 1'b1;
               state_nxt = IDLE;
            end else begin
               wait_nxt = wait_q + 1'b1;
            end
         end
         FIN: begin
            done_c    = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   // every output is forced low while reset is held, even before the edge
   assign cmd_ready = (state == IDLE) && reset;
   assign busy      = (state != IDLE) && reset;
   assign mem_req   = req_c && reset;
   assign acc_write = write_c && reset;
   assign acc_src   = src_c && reset;
   assign done      = done_c && reset;
   assign err       = err_q && reset;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer with a local accumulator model.
module tb_acc_sequencer;

   localparam int CW = 8;
   localparam int TO = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [CW-1:0] cmd_count = '0;
   logic          mem_req;
   logic          mem_ack = 1'b0;
   logic          acc_write;
   logic          acc_src;
   logic          busy;
   logic          done;
   logic          err;

   logic [7:0] acc;
   logic [7:0] acc_init = 8'h00;
   logic       acc_ld = 1'b0;
   logic [7:0] mem_out = 8'h5A;

   int checks = 0;
   int failures = 0;

   acc_sequencer #(
      .COUNT_W    (CW),
      .MEM_TIMEOUT(TO)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op   (cmd_op),
      .cmd_count(cmd_count),
      .mem_req  (mem_req),
      .mem_ack  (mem_ack),
      .acc_write(acc_write),
      .acc_src  (acc_src),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clock = ~clock;

   // accumulator datapath: ALU does +1, memory supplies mem_out
   always @(posedge clock) begin
      if (acc_ld)
         acc <= acc_init;
      else if (acc_write)
         acc <= acc_src ? mem_out : acc + 8'd1;
   end

   typedef struct {
      logic [1:0] op;
      logic [7:0] cnt;
      int         ack_d;
      logic [7:0] acc0;
      int         writes;
      int         lat;
      int         reqs;
      logic       err_exp;
      logic [7:0] acc_exp;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [7:0] cnt,
                        input string name);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_count = cnt;
      @(negedge clock);
      check({name, "_ready"}, 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_count = '0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string nm;
      int    writes;
      int    reqs;
      int    lat;
      int    bad_src;
      bit    got;
      nm      = $sformatf("vec%0d", idx);
      writes  = 0;
      reqs    = 0;
      lat     = 0;
      bad_src = 0;
      got     = 1'b0;
      acc_init = v.acc0;
      acc_ld   = 1'b1;
      step();
      acc_ld = 1'b0;
      issue(v.op, v.cnt, nm);
      for (int c = 1; c <= 400 && !got; c++) begin
         mem_ack = mem_req && (reqs == v.ack_d);
         @(negedge clock);
         if (acc_write) begin
            writes++;
            if (acc_src !== (v.op == 2'b10))
               bad_src++;
         end
         if (mem_req)
            reqs++;
         if (done === 1'b1) begin
            got = 1'b1;
            lat = c;
         end
         step();
      end
      mem_ack = 1'b0;
      check({nm, "_done_seen"}, 32'(got), 32'd1);
      check({nm, "_latency"}, 32'(lat), 32'(v.lat));
      check({nm, "_writes"}, 32'(writes), 32'(v.writes));
      check({nm, "_req_cycles"}, 32'(reqs), 32'(v.reqs));
      check({nm, "_src"}, 32'(bad_src), 32'd0);
      @(negedge clock);
      check({nm, "_ready_after"}, 32'(cmd_ready), 32'd1);
      check({nm, "_single_done"}, 32'(done), 32'd0);
      check({nm, "_busy_after"}, 32'(busy), 32'd0);
      check({nm, "_err"}, 32'(err), 32'(v.err_exp));
      check({nm, "_acc"}, 32'(acc), 32'(v.acc_exp));
      step();
   endtask

   initial begin
      int bad;
      int wr;

      // op cnt ack_d acc0 writes lat reqs err acc_exp
      vecs[0] = '{2'b01, 8'd3,   0,    8'd5,  3,   3,   0,  1'b0, 8'd8};
      vecs[1] = '{2'b01, 8'd0,   0,    8'd10, 1,   1,   0,  1'b0, 8'd11};
      vecs[2] = '{2'b01, 8'd255, 0,    8'd0,  255, 255, 0,  1'b0, 8'd255};
      vecs[3] = '{2'b00, 8'd9,   0,    8'd7,  0,   1,   0,  1'b0, 8'd7};
      vecs[4] = '{2'b10, 8'd0,   4,    8'd0,  1,   5,   5,  1'b0, 8'h5A};
      vecs[5] = '{2'b10, 8'd0,   1000, 8'h11, 0,   16,  16, 1'b1, 8'h11};
      vecs[6] = '{2'b00, 8'd0,   0,    8'd3,  0,   1,   0,  1'b0, 8'd3};
      vecs[7] = '{2'b11, 8'd4,   0,    8'd6,  0,   1,   0,  1'b1, 8'd6};
      vecs[8] = '{2'b10, 8'd0,   0,    8'd1,  1,   1,   1,  1'b0, 8'h5A};
      vecs[9] = '{2'b10, 8'd0,   15,   8'd2,  1,   16,  16, 1'b0, 8'h5A};

      // reset held three cycles: every output low
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check($sformatf("reset_outs%0d", i),
               {25'd0, cmd_ready, busy, done, err, mem_req, acc_write,
                acc_src}, 32'd0);
      end
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      check("ready_after_reset", 32'(cmd_ready), 32'd1);
      step();

      foreach (vecs[i])
         run_vec(vecs[i], i);

      // cmd_valid held through an ALU run of 5
      issue(2'b01, 8'd5, "hold");
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_count = 8'd2;
      bad = 0;
      wr  = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         if (cmd_ready !== 1'b0)
            bad++;
         if (acc_write === 1'b1)
            wr++;
         step();
      end
      check("hold_no_ready", 32'(bad), 32'd0);
      check("hold_writes", 32'(wr), 32'd5);
      @(negedge clock);
      check("hold_ready_back", 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
      @(negedge clock);
      check("hold_second_c1",
            {30'd0, acc_write, done}, {30'd0, 1'b1, 1'b0});
      step();
      @(negedge clock);
      check("hold_second_c2",
            {30'd0, acc_write, done}, {30'd0, 1'b1, 1'b1});
      step();

      // reset in the third MEM_REQ cycle, then a late ack
      issue(2'b10, 8'd0, "rst_load");
      @(negedge clock);
      check("rst_load_req", 32'(mem_req), 32'd1);
      step();
      step();
      reset = 1'b0;
      @(negedge clock);
      check("rst_mid_outs",
            {29'd0, mem_req, acc_write, done}, 32'd0);
      step();
      reset = 1'b1;
      mem_ack = 1'b1;
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         if ({mem_req, acc_write, done, busy} !== 4'b0000)
            bad++;
         step();
      end
      mem_ack = 1'b0;
      check("late_ack_ignored", 32'(bad), 32'd0);
      @(negedge clock);
      check("ready_after_abort", 32'(cmd_ready), 32'd1);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
- Controls the accumulator unit of the BeeF core by driving its write enable (acc_write) and source select (acc_src: 0 = ALU result, 1 = memory data).
- Accepts one command at a time from the decoder over a valid/ready handshake:
  - NOP;
  - ALU write repeated N times, used for run-length-compressed "+"/"-" sequences;
  - memory LOAD, using a req/ack handshake with a timeout.
- Sits between the instruction decoder and the accumulator datapath.

Parameters:
- COUNT_W, 8, width of the repeat count.
- MEM_TIMEOUT, 16, number of MEM_REQ cycles without mem_ack before a LOAD aborts (minimum 1).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  decoder presents a command.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 NOP, 01 ALU, 10 LOAD, 11 reserved.
- cmd_count  in  COUNT_W  ALU repeat count; 0 is treated as 1; ignored for other ops.
- mem_req  out  1  memory read request.
- mem_ack  in  1  memory data valid on mem_out this cycle.
- acc_write  out  1  accumulator write enable.
- acc_src  out  1  accumulator source select.
- busy  out  1  command in progress (state != IDLE).
- done  out  1  one-cycle pulse on command completion.
- err  out  1  sticky error flag; cleared when the next command is accepted.

Behaviour:
- Reset (reset == 0 at a clock edge):
  - state = IDLE; remaining count = 0; wait count = 0.
  - All outputs 0, including cmd_ready, while reset is held.
  - Reset mid-operation aborts immediately: mem_req drops, no acc_write, no done pulse.
- States: IDLE, ALU_RUN, MEM_REQ, FIN.
- Accept rule:
  - A command is accepted in the cycle cmd_valid && cmd_ready.
  - cmd_ready = (state == IDLE) && reset.
  - Acceptance clears err.
  - cmd_op and cmd_count are sampled only at acceptance.
- IDLE transitions on accept:
  - ALU -> ALU_RUN; remaining count = max(cmd_count, 1).
  - LOAD -> MEM_REQ; wait count = 0.
  - NOP -> FIN.
  - Reserved op (11) -> FIN with err set.
- ALU_RUN:
  - acc_write = 1, acc_src = 0 every cycle; the ALU re-evaluates from the new acc each cycle.
  - Remaining count decrements each cycle.
  - In the cycle remaining == 1: done = 1, next state IDLE.
  - Timing: command accepted at cycle T with count N produces writes at T+1 through T+N, done at T+N, cmd_ready at T+N+1.
- MEM_REQ:
  - mem_req = 1 and acc_src = 1 for every cycle in this state.
  - If mem_ack = 1: acc_write = 1 in that same cycle (combinational from mem_ack), done = 1, next state IDLE.
  - Otherwise wait count increments.
  - If wait count reaches MEM_TIMEOUT-1 and mem_ack = 0 in that cycle: err set, done = 1, no write, next state IDLE.
  - Total request window is exactly MEM_TIMEOUT cycles.
- FIN: done = 1, no write, next state IDLE. A NOP accepted at T gives done at T+1.
- Default output values:
  - acc_src = 0 and mem_req = 0 outside MEM_REQ.
  - acc_write = 0 outside the write cases above.
  - mem_ack outside MEM_REQ is ignored.
- Invariants:
  - acc_write and mem_req never depend on cmd_valid.
  - Exactly one done pulse per accepted command.
- Remaining-count arithmetic is unsigned COUNT_W. cmd_count = 2^COUNT_W-1 (255) gives 255 writes, with no wrap.

Test Plan:
- Reset held 3 cycles, then released; ALU cmd_count=3 accepted at T -> acc_write=1, acc_src=0 at T+1..T+3; done at T+3; cmd_ready=1 at T+4; acc goes 5 -> 8 with ALU doing +1.
- ALU cmd_count=0 -> exactly 1 write cycle; done in the same cycle as that write.
- LOAD with mem_ack 4 cycles after mem_req rises and mem_out=0x5A -> single acc_write with acc_src=1 in the ack cycle; acc=0x5A; done=1; err=0.
- LOAD with no ack, MEM_TIMEOUT=16 -> mem_req high exactly 16 cycles; no acc_write; done and err=1; the next NOP accepted clears err.
- Reserved op 11 -> err=1, done at T+1, no writes. cmd_valid held high in ALU_RUN for count=5 -> no accept until state returns to IDLE.
- reset=0 asserted in the 3rd cycle of MEM_REQ -> mem_req=0, busy=0 next edge; late mem_ack after reset produces no write and no done.
